led_seq_ctrl: RTL

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_pkg.sv | 26 ++
 rtl/key_debounce.sv | 65 ++++++
 rtl/led_seq_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode encoding and default parameters for the LED sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    SHIFT = 2'd1,
    BLINK = 2'd2,
    HOLD  = 2'd3
  } mode_e;

  localparam int DEF_LEDS_NR         = 6;
  localparam int DEF_INV_BTN         = 0;
  localparam int DEF_PRESCALE_W      = 22;
  localparam int DEF_DEBOUNCE_CYCLES = 65535;

  // Modes cycle COUNT -> SHIFT -> BLINK -> HOLD -> COUNT on each button press.
  function automatic mode_e next_mode(input mode_e m);
    unique case (m)
      COUNT: return SHIFT;
      SHIFT: return BLINK;
      BLINK: return HOLD;
      HOLD:  return COUNT;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - button synchronizer, debouncer and one-cycle press event
module key_debounce
  import led_seq_pkg::*;
#(
  parameter int INV_BTN         = DEF_INV_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);

  localparam logic INV = (INV_BTN != 0);
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic             deb_dly_q, deb_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Next-state: polarity-normalize then synchronize; accept a level only after it
  // disagrees with the debounced level for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    sync1_d   = key_i ^ INV;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    cnt_d     = '0;
    deb_dly_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Rising edge of the debounced level, registered so it lasts one cycle.
    press_d = deb_q & ~deb_dly_q;
  end

  // State registers; reset drops all debounce progress so no stale event survives.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - button-stepped LED pattern sequencer with prescaler
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int LEDS_NR         = DEF_LEDS_NR,
  parameter int INV_BTN         = DEF_INV_BTN,
  parameter int PRESCALE_W      = DEF_PRESCALE_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               key_i,
  output logic [LEDS_NR-1:0] led,
  output logic [1:0]         mode_o,
  output logic               tick_o
);

  logic [PRESCALE_W-1:0] ctr_q, ctr_d;
  mode_e                 state_q, state_d;
  logic [LEDS_NR-1:0]    led_q, led_d;
  logic [LEDS_NR-1:0]    pat_q, pat_d;
  logic                  press;
  logic                  tick;
  logic [LEDS_NR-1:0]    ctr_view;

  key_debounce #(
    .INV_BTN        (INV_BTN),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst_i  (rst_i),
    .key_i  (key_i),
    .press_o(press)
  );

  assign tick     = &ctr_q;
  assign ctr_view = ctr_q[PRESCALE_W-1 -: LEDS_NR];

  // Next-state and LED datapath: a press changes mode and loads that mode's entry
  // value, taking priority over any tick in the same cycle.
  always_comb begin
    ctr_d   = ctr_q + 1'b1;
    state_d = state_q;
    led_d   = led_q;
    pat_d   = pat_q;
    if (press) begin
      state_d = next_mode(state_q);
      unique case (state_d)
        COUNT: led_d = ctr_view;
        SHIFT: begin
          pat_d = LEDS_NR'(1);
          led_d = LEDS_NR'(1);
        end
        BLINK: led_d = '0;
        HOLD:  led_d = led_q;
      endcase
    end else begin
      unique case (state_q)
        COUNT: led_d = ctr_view;
        SHIFT: begin
          if (tick) begin
            pat_d = {pat_q[LEDS_NR-2:0], pat_q[LEDS_NR-1]};
          end
          led_d = pat_d;
        end
        BLINK: begin
          if (tick) begin
            led_d = ~led_q;
          end
        end
        HOLD:  led_d = led_q;
      endcase
    end
  end

  // State register for mode, prescaler, LED drive and rotating pattern.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      ctr_q   <= '0;
      state_q <= COUNT;
      led_q   <= '0;
      pat_q   <= LEDS_NR'(1);
    end else begin
      ctr_q   <= ctr_d;
      state_q <= state_d;
      led_q   <= led_d;
      pat_q   <= pat_d;
    end
  end

  assign led    = led_q;
  assign mode_o = state_q;
  assign tick_o = tick;

endmodule
